// File: rtl/accel_pkg.sv
// Shared accelerator definitions: default word width, 2x2 window positions
// and the unpool sequencer states.
package accel_pkg;

    localparam int DATA_WIDTH_DEF = 16;

    localparam logic [1:0] IDX_TL = 2'd0;
    localparam logic [1:0] IDX_TR = 2'd1;
    localparam logic [1:0] IDX_BL = 2'd2;
    localparam logic [1:0] IDX_BR = 2'd3;

    typedef enum logic [1:0] {
        LOAD     = 2'd0,
        EMIT_TOP = 2'd1,
        EMIT_BOT = 2'd2
    } unpool_state_t;

    // Window position of an output pixel: {output row within the pair, column parity}.
    function automatic logic [1:0] win_pos(input logic row_sel, input logic sub);
        return {row_sel, sub};
    endfunction

endpackage

// File: rtl/max_unpool_if.sv
// Stream bundle for max_unpool: pooled input side, unpooled output side and row config.
interface max_unpool_if #(
    parameter int DATA_WIDTH = accel_pkg::DATA_WIDTH_DEF,
    parameter int MAX_W      = 64
);
    logic [$clog2(MAX_W):0]  cfg_width;
    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_WIDTH-1:0]   in_data;
    logic [1:0]              in_idx;
    logic                    in_last;
    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_WIDTH-1:0]   out_data;
    logic                    out_row_end;
    logic                    out_last;

    modport master (
        output cfg_width, in_valid, in_data, in_idx, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_row_end, out_last
    );

    modport slave (
        input  cfg_width, in_valid, in_data, in_idx, in_last, out_ready,
        output in_ready, out_valid, out_data, out_row_end, out_last
    );
endinterface

// File: rtl/unpool_line_buf.sv
// One pooled row of {value, argmax index}: synchronous write, combinational read.
module unpool_line_buf #(
    parameter int DATA_WIDTH = accel_pkg::DATA_WIDTH_DEF,
    parameter int MAX_W      = 64
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(MAX_W)-1:0]   waddr,
    input  logic [DATA_WIDTH+1:0]      wdata,
    input  logic [$clog2(MAX_W)-1:0]   raddr,
    output logic [DATA_WIDTH+1:0]      rdata
);
    logic [DATA_WIDTH+1:0] mem [MAX_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/max_unpool.sv
// 2x2 max-unpooling: buffers one pooled row, then emits the top and bottom
// output rows with the value placed at its argmax position and zeros elsewhere.
module max_unpool
    import accel_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int MAX_W      = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    max_unpool_if.slave   bus
);
    localparam int AW = $clog2(MAX_W);
    localparam int CW = AW + 1;
    localparam int OW = CW + 1;
    localparam int EW = DATA_WIDTH + 2;

    unpool_state_t          state;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          w_lat;
    logic [CW-1:0]          weff;
    logic [OW-1:0]          col;
    logic                   frame_end;
    logic                   in_ready_r;
    logic                   out_valid_r;
    logic [DATA_WIDTH-1:0]  out_data_r;
    logic                   out_row_end_r;
    logic                   out_last_r;

    logic                   in_fire;
    logic                   out_fire;
    logic                   row_close;
    logic                   col_end;
    logic [CW-1:0]          cfg_sat;
    logic [CW-1:0]          w_cur;
    logic [OW-1:0]          ncol;
    logic                   nrow_sel;
    logic [CW-1:0]          nweff;
    logic                   nframe;
    logic [AW-1:0]          raddr;
    logic [EW-1:0]          rd_entry;
    logic [EW-1:0]          entry;
    logic [DATA_WIDTH-1:0]  nxt_data;
    logic                   nxt_row_end;
    logic                   nxt_last;

    assign bus.in_ready    = in_ready_r;
    assign bus.out_valid   = out_valid_r;
    assign bus.out_data    = out_data_r;
    assign bus.out_row_end = out_row_end_r;
    assign bus.out_last    = out_last_r;

    unpool_line_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_W      (MAX_W)
    ) u_line_buf (
        .clk   (clk),
        .we    (in_fire),
        .waddr (cnt[AW-1:0]),
        .wdata ({bus.in_data, bus.in_idx}),
        .raddr (raddr),
        .rdata (rd_entry)
    );

    always_comb begin
        in_fire  = bus.in_valid && in_ready_r && (state == LOAD);
        out_fire = out_valid_r && bus.out_ready;

        if (bus.cfg_width == '0) begin
            cfg_sat = CW'(1);
        end else if (bus.cfg_width > CW'(MAX_W)) begin
            cfg_sat = CW'(MAX_W);
        end else begin
            cfg_sat = bus.cfg_width;
        end

        w_cur     = (cnt == '0) ? cfg_sat : w_lat;
        row_close = in_fire && (bus.in_last || (cnt == w_cur - CW'(1)));
        col_end   = ((col + OW'(1)) == {weff, 1'b0});

        // Next output element is prepared one step ahead so outputs stay registered.
        ncol     = '0;
        nrow_sel = 1'b0;
        nweff    = weff;
        nframe   = frame_end;
        if (state == LOAD) begin
            nweff  = cnt + CW'(1);
            nframe = bus.in_last;
        end else if (col_end) begin
            nrow_sel = 1'b1;
        end else begin
            ncol     = col + OW'(1);
            nrow_sel = (state == EMIT_BOT);
        end

        raddr = ncol[AW:1];
        // A one-element row closes on the same cycle its entry is written.
        entry = ((state == LOAD) && (cnt == '0)) ? {bus.in_data, bus.in_idx} : rd_entry;

        nxt_data    = (entry[1:0] == win_pos(nrow_sel, ncol[0])) ? entry[EW-1:2] : '0;
        nxt_row_end = ((ncol + OW'(1)) == {nweff, 1'b0});
        nxt_last    = nxt_row_end && nrow_sel && nframe;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= LOAD;
            cnt           <= '0;
            w_lat         <= '0;
            weff          <= '0;
            col           <= '0;
            frame_end     <= 1'b0;
            in_ready_r    <= 1'b0;
            out_valid_r   <= 1'b0;
            out_data_r    <= '0;
            out_row_end_r <= 1'b0;
            out_last_r    <= 1'b0;
        end else begin
            unique case (state)
                LOAD: begin
                    in_ready_r <= 1'b1;
                    if (in_fire) begin
                        cnt <= cnt + CW'(1);
                        if (cnt == '0) begin
                            w_lat <= cfg_sat;
                        end
                        if (row_close) begin
                            state         <= EMIT_TOP;
                            in_ready_r    <= 1'b0;
                            weff          <= nweff;
                            frame_end     <= nframe;
                            col           <= ncol;
                            out_valid_r   <= 1'b1;
                            out_data_r    <= nxt_data;
                            out_row_end_r <= nxt_row_end;
                            out_last_r    <= nxt_last;
                        end
                    end
                end
                EMIT_TOP, EMIT_BOT: begin
                    if (out_fire) begin
                        if (col_end && (state == EMIT_BOT)) begin
                            state         <= LOAD;
                            cnt           <= '0;
                            frame_end     <= 1'b0;
                            col           <= '0;
                            in_ready_r    <= 1'b1;
                            out_valid_r   <= 1'b0;
                            out_row_end_r <= 1'b0;
                            out_last_r    <= 1'b0;
                        end else begin
                            if (col_end) begin
                                state <= EMIT_BOT;
                            end
                            col           <= ncol;
                            out_data_r    <= nxt_data;
                            out_row_end_r <= nxt_row_end;
                            out_last_r    <= nxt_last;
                        end
                    end
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_max_unpool.sv
// Directed bench for max_unpool: hand-computed unpooled rows, stalls, width
// clamping, mid-emit reset and input back-pressure during emit.
module tb_max_unpool;
    import accel_pkg::*;

    localparam int DW = 16;
    localparam int MW = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    max_unpool_if #(.DATA_WIDTH(DW), .MAX_W(MW)) bus ();

    max_unpool #(.DATA_WIDTH(DW), .MAX_W(MW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [15:0] d, input logic [1:0] idx, input logic last,
                        input string tag);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_idx   = idx;
        bus.in_last  = last;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_accept_in_time"}, 32'(n < 50), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Checks one output element (optionally with a one-cycle stall) and accepts it.
    task automatic recv(input logic [15:0] d, input logic re, input logic last,
                        input logic stall, input string tag);
        int n = 0;
        while (bus.out_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_wait"}, n, 0);
        chk({tag, "_data"}, bus.out_data, d);
        chk({tag, "_row_end"}, bus.out_row_end, re);
        chk({tag, "_last"}, bus.out_last, last);
        chk({tag, "_in_ready"}, bus.in_ready, 1'b0);
        if (stall) begin
            bus.out_ready = 1'b0;
            @(negedge clk);
            chk({tag, "_hold_valid"}, bus.out_valid, 1'b1);
            chk({tag, "_hold_data"}, bus.out_data, d);
            chk({tag, "_hold_row_end"}, bus.out_row_end, re);
            chk({tag, "_hold_last"}, bus.out_last, last);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  ix;
        logic [15:0] ev;
        bus.cfg_width = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_idx    = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1'b0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_data", bus.out_data, 16'h0000);
        chk("rst_row_end", bus.out_row_end, 1'b0);
        chk("rst_last", bus.out_last, 1'b0);
        rst_n = 1'b1;
        chk("rel_in_ready_pre", bus.in_ready, 1'b0);
        @(negedge clk);
        chk("rel_in_ready", bus.in_ready, 1'b1);

        // Basic W=2 frame, continuous out_ready
        bus.cfg_width = 7'd2;
        send(16'h0005, IDX_TL, 1'b0, "a0");
        send(16'h8003, IDX_BR, 1'b1, "a1");
        chk("a_first_valid", bus.out_valid, 1'b1);
        recv(16'h0005, 0, 0, 0, "a_t0");
        recv(16'h0000, 0, 0, 0, "a_t1");
        recv(16'h0000, 0, 0, 0, "a_t2");
        recv(16'h0000, 1, 0, 0, "a_t3");
        recv(16'h0000, 0, 0, 0, "a_b0");
        recv(16'h0000, 0, 0, 0, "a_b1");
        recv(16'h0000, 0, 0, 0, "a_b2");
        recv(16'h8003, 1, 1, 0, "a_b3");
        chk("a_done_valid", bus.out_valid, 1'b0);
        chk("a_done_in_ready", bus.in_ready, 1'b1);

        // Same frame with out_ready toggling
        send(16'h0005, IDX_TL, 1'b0, "s0");
        send(16'h8003, IDX_BR, 1'b1, "s1");
        recv(16'h0005, 0, 0, 1, "s_t0");
        recv(16'h0000, 0, 0, 1, "s_t1");
        recv(16'h0000, 0, 0, 1, "s_t2");
        recv(16'h0000, 1, 0, 1, "s_t3");
        recv(16'h0000, 0, 0, 1, "s_b0");
        recv(16'h0000, 0, 0, 1, "s_b1");
        recv(16'h0000, 0, 0, 1, "s_b2");
        recv(16'h8003, 1, 1, 1, "s_b3");
        chk("s_done_valid", bus.out_valid, 1'b0);

        // Early in_last: cfg 4, closes at 2 elements; negative zero passes through
        bus.cfg_width = 7'd4;
        send(16'h0011, IDX_TR, 1'b0, "e0");
        send(16'h8000, IDX_BL, 1'b1, "e1");
        recv(16'h0000, 0, 0, 0, "e_t0");
        recv(16'h0011, 0, 0, 0, "e_t1");
        recv(16'h0000, 0, 0, 0, "e_t2");
        recv(16'h0000, 1, 0, 0, "e_t3");
        recv(16'h0000, 0, 0, 0, "e_b0");
        recv(16'h0000, 0, 0, 0, "e_b1");
        recv(16'h8000, 0, 0, 0, "e_b2");
        recv(16'h0000, 1, 1, 0, "e_b3");
        chk("e_done_valid", bus.out_valid, 1'b0);

        // cfg_width 0 acts as 1
        bus.cfg_width = 7'd0;
        send(16'h0007, IDX_BL, 1'b0, "z0");
        recv(16'h0000, 0, 0, 0, "z_t0");
        recv(16'h0000, 1, 0, 0, "z_t1");
        recv(16'h0007, 0, 0, 0, "z_b0");
        recv(16'h0000, 1, 0, 0, "z_b1");
        chk("z_done_valid", bus.out_valid, 1'b0);

        // cfg_width above MAX_W saturates: row closes after MAX_W elements without in_last
        bus.cfg_width = 7'(MW + 5);
        for (int i = 0; i < MW; i++) begin
            chk("m_no_early_close", bus.out_valid, 1'b0);
            send(16'h0100 + 16'(i), 2'(i % 4), 1'b0, "m_in");
        end
        chk("m_close_valid", bus.out_valid, 1'b1);
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2 * MW; c++) begin
                ix = 2'((c / 2) % 4);
                ev = (ix == {1'(r), 1'(c % 2)}) ? (16'h0100 + 16'(c / 2)) : 16'h0000;
                recv(ev, (c == 2 * MW - 1), 1'b0, 1'b0, $sformatf("m_r%0d_c%0d", r, c));
            end
        end
        chk("m_done_valid", bus.out_valid, 1'b0);

        // Reset in the middle of EMIT_TOP
        bus.cfg_width = 7'd2;
        send(16'h0005, IDX_TL, 1'b0, "r0");
        send(16'h0006, IDX_TR, 1'b1, "r1");
        recv(16'h0005, 0, 0, 0, "r_t0");
        recv(16'h0000, 0, 0, 0, "r_t1");
        rst_n = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("r_rst_out_valid", bus.out_valid, 1'b0);
        chk("r_rst_in_ready", bus.in_ready, 1'b0);
        chk("r_rst_out_data", bus.out_data, 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);
        chk("r_rel_in_ready", bus.in_ready, 1'b1);
        chk("r_rel_out_valid", bus.out_valid, 1'b0);
        bus.cfg_width = 7'd1;
        send(16'h1234, IDX_BR, 1'b1, "r2");
        recv(16'h0000, 0, 0, 0, "r_n_t0");
        recv(16'h0000, 1, 0, 0, "r_n_t1");
        recv(16'h0000, 0, 0, 0, "r_n_b0");
        recv(16'h1234, 1, 1, 0, "r_n_b1");

        // in_valid held through EMIT must not be accepted until LOAD
        bus.cfg_width = 7'd1;
        send(16'h0022, IDX_TL, 1'b0, "h0");
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h0033;
        bus.in_idx   = IDX_TR;
        bus.in_last  = 1'b1;
        recv(16'h0022, 0, 0, 0, "h_t0");
        recv(16'h0000, 1, 0, 0, "h_t1");
        recv(16'h0000, 0, 0, 0, "h_b0");
        recv(16'h0000, 1, 0, 0, "h_b1");
        chk("h_load_in_ready", bus.in_ready, 1'b1);
        send(16'h0033, IDX_TR, 1'b1, "h1");
        recv(16'h0000, 0, 0, 0, "h2_t0");
        recv(16'h0033, 1, 0, 0, "h2_t1");
        recv(16'h0000, 0, 0, 0, "h2_b0");
        recv(16'h0000, 1, 1, 0, "h2_b1");
        chk("h2_done_valid", bus.out_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
